enc8to3_scan: RTL
=================

# enc8to3_scan

Round-robin 8-to-3 line encoder with a registered request set, the return path of the 3-to-8 address decoder. It captures request lines (multi-hot allowed) into a pending set. It then presents each pending line, one at a time, as a 3-bit address on a valid/ready output. It sits between the latch-enable/request fabric and whichever controller consumes line addresses.

## Interface
- `N_LINES`, 8 — number of request lines; fixed at 8 for this revision.
- `ADDR_W`, 3 — address width; equals clog2(`N_LINES`).
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req` in 8 — request lines, level-sampled every cycle, multi-hot allowed.
- `en` in 1 — capture enable; when low, `req` is ignored.
- `addr` out 3 — encoded line index being presented.
- `valid` out 1 — `addr` is valid.
- `ready` in 1 — consumer accepts `addr` this cycle.
- `pending` out 8 — registered pending set.
- `count` out 4 — popcount of `pending` (0..8).
- `busy` out 1 — high when `pending` is non-zero or `valid` is high.

## Operation
- Capture: each edge, `pending <= (pending & ~clr) | (req & {8{en}})`.
  - `clr` is the one-hot of `addr` when `valid && ready`, otherwise 0.
  - If set and clear hit the same bit in the same cycle, set wins and the line is re-queued.
- `en` low: no new bits are set. Draining of existing pending bits continues unaffected.
- Selection: round-robin search of `pending` starting at pointer `ptr` (3 bits), ascending with wrap 7→0. The first set bit wins.
- State machine, two states:
  - IDLE:
    - If `pending` is non-zero, load `addr` with the selected index, set `valid`, go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT:
    - `addr` and `valid` are held stable while `ready` is low.
    - On handshake (`valid && ready`), `ptr <= addr + 1` (mod 8).
    - After a handshake, the next candidate is selected from `(pending & ~clr)` plus the current-cycle capture, searching from `addr + 1`.
      - If a candidate exists: load it and stay in PRESENT with `valid` high, giving back-to-back transfers.
      - If none: clear `valid` and go to IDLE.
- A line that is currently presented is not re-presented until its handshake completes. A re-request arriving in the handshake cycle re-queues it behind the other pending lines.
- `count` is the registered popcount of `pending` and is updated on the same edge as `pending`.
- `busy = |pending | valid`. It is combinational from registers.

## Timing
- Reset values: `addr` = 0, `valid` = 0, `pending` = 0, `count` = 0, `busy` = 0; `ptr` = 0; state IDLE.
- Latency: `req` high in cycle t → `pending` bit set at edge t+1 → `valid` high at edge t+2. First-address latency is 2 cycles.
- Throughput: one address per cycle while `ready` is held high and `pending` is non-empty.
- The handshake completes on the edge where `valid && ready`. `ready` may be high while `valid` is low; this has no effect.
- Reset asserted mid-transfer: all state clears immediately (asynchronous) and `valid` drops without a handshake. Pending requests are lost.
- Empty boundary: the last handshake with no new requests leaves `valid` low on the next edge and `busy` low in the same cycle.
- Full boundary: all 8 bits set gives `count` = 8. `count` never exceeds 8 because it is the popcount of 8 bits.

## Structure
- Package `enc_pkg`: `N_LINES`, `ADDR_W`, and the state enum (IDLE, PRESENT).
- Sub-module `rr_pick8`: purely combinational. Inputs are an 8-bit mask and a 3-bit start index; outputs are `found` and a 3-bit index. It is instantiated once, fed with the next-pending value.
- The top level holds the pending register, pointer, state machine, and popcount.

## Test plan
- Reset, then one-cycle pulse `req` = 8'b0000_0100 with `en` = 1 and `ready` = 1 → `valid` rises 2 cycles later with `addr` = 2, held for one cycle. `pending` then reads 0, `busy` goes low, `count` goes 1→0.
- `req` = 8'hFF for one cycle, `ready` = 1 → `addr` sequence 0,1,…,7 on 8 consecutive cycles. `count` goes 8,7,…,1,0.
- `ptr` = 5 (after serving line 4), then `req` = 8'b0010_0011 → order is 5, 0, 1, demonstrating wrap-around.
- Stall: `pending` = {3, 6}, `ready` = 0 for 5 cycles → `addr` = 3 is held stable with `valid` high. Release `ready` → 3 then 6.
- Simultaneous events: `req[3]` high in the same cycle as the `addr` = 3 handshake, with `pending` = {3, 7} → next address 7, then 3 again. `count` holds at 2 across that edge.
- `en` = 0 with `req` = 8'hFF → `pending` unchanged and `busy` stays 0. Asserting `rst_n` = 0 mid-PRESENT immediately sets `valid` = 0 and `pending` = 0.

Source files
------------

// File: rtl/enc8to3_scan_pkg.sv
// Shared constants, FSM state type and popcount helper for the round-robin
// 8-to-3 line encoder.
package enc_pkg;

    localparam int unsigned N_LINES = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] popcount8(input logic [N_LINES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N_LINES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/enc8to3_scan_rr_pick8.sv
// Combinational round-robin picker: first set bit of mask_i searching
// upward from start_i with wrap 7 -> 0.
module rr_pick8
    import enc_pkg::*;
(
    input  logic [N_LINES-1:0] mask_i,
    input  logic [ADDR_W-1:0]  start_i,
    output logic               found_o,
    output logic [ADDR_W-1:0]  idx_o
);

    logic [ADDR_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_LINES; k++) begin
            cand = start_i + ADDR_W'(k);
            if (!found_o && mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/enc8to3_scan.sv
// Round-robin 8-to-3 encoder: captures multi-hot requests into a pending set
// and presents each pending line as an address on a valid/ready output.
module enc8to3_scan
    import enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] req,
    input  logic               en,
    output logic [ADDR_W-1:0]  addr,
    output logic               valid,
    input  logic               ready,
    output logic [N_LINES-1:0] pending,
    output logic [CNT_W-1:0]   count,
    output logic               busy
);

    state_e             state_q;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   count_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic               valid_q;

    logic               hs;
    logic [N_LINES-1:0] clr;
    logic [N_LINES-1:0] pick_mask;
    logic [ADDR_W-1:0]  pick_start;
    logic               pick_found;
    logic [ADDR_W-1:0]  pick_idx;

    // Set is ORed in after the clear, so a re-request of the line being
    // handed off re-queues it; searching from addr+1 puts it behind the rest.
    always_comb begin
        hs  = valid_q & ready;
        clr = '0;
        if (hs) begin
            clr[addr_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | (req & {N_LINES{en}});
        // IDLE looks at the registered set only, giving the two-cycle
        // request-to-valid latency; PRESENT chains straight to the next line.
        if (state_q == PRESENT) begin
            pick_mask  = pending_d;
            pick_start = addr_q + ADDR_W'(1);
        end else begin
            pick_mask  = pending_q;
            pick_start = ptr_q;
        end
    end

    rr_pick8 u_pick (
        .mask_i  (pick_mask),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= popcount8(pending_d);
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        addr_q  <= pick_idx;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (hs) begin
                        ptr_q <= addr_q + ADDR_W'(1);
                        if (pick_found) begin
                            addr_q <= pick_idx;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign addr    = addr_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign count   = count_q;
    assign busy    = (|pending_q) | valid_q;

endmodule
